// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit.
// Prediction record, FSM states and PC step.
package bru_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
   } bru_rec_t;

   typedef enum logic {
      BRU_RUN,
      BRU_RECOVER
   } bru_state_t;

   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-flight prediction record FIFO.
// Flush has priority over push and pop.
module bru_pred_fifo
   import bru_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  logic     pop,
   input  logic     flush,
   input  bru_rec_t wdata,
   output logic     full,
   output logic     empty,
   output bru_rec_t head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   bru_rec_t      mem_q [DEPTH];
   bru_rec_t      mem_d [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Next pointer/count/storage; a push into a full queue only lands
   // when a pop frees the head slot in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      do_push  = push && (!full || pop);
      do_pop   = pop && !empty;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Queue state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: match predictions,
// detect mispredicts, redirect fetch and update the BTB.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 bru_clk,
   input  logic                 bru_reset,
   input  logic                 fe_push,
   input  logic [31:0]          fe_pc,
   input  logic [31:0]          fe_target,
   output logic                 fe_stall,
   input  logic                 ex_valid,
   input  logic [31:0]          ex_pc,
   input  logic                 ex_is_branch,
   input  logic                 ex_taken,
   input  logic [31:0]          ex_target,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic                 btb_write,
   output logic [31:0]          btb_new_pc,
   output logic [31:0]          btb_data,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] stat_branches,
   output logic [CNT_WIDTH-1:0] stat_mispredicts
);

   bru_state_t           state_q, state_d;
   logic                 redirect_valid_q, redirect_valid_d;
   logic [31:0]          redirect_pc_q, redirect_pc_d;
   logic                 btb_write_q, btb_write_d;
   logic [31:0]          btb_new_pc_q, btb_new_pc_d;
   logic [31:0]          btb_data_q, btb_data_d;
   logic                 overflow_q, overflow_d;
   logic [CNT_WIDTH-1:0] stat_branches_q, stat_branches_d;
   logic [CNT_WIDTH-1:0] stat_mispredicts_q, stat_mispredicts_d;

   logic     q_full, q_empty, q_push, q_pop, q_flush;
   bru_rec_t q_head, q_wdata;
   logic     run, hit, taken_br, miss_tgt, miss_dir, mispred;

   bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (bru_clk),
      .rst   (bru_reset),
      .push  (q_push),
      .pop   (q_pop),
      .flush (q_flush),
      .wdata (q_wdata),
      .full  (q_full),
      .empty (q_empty),
      .head  (q_head)
   );

   // Match against the oldest record and classify the outcome.
   always_comb begin
      run      = (state_q == BRU_RUN);
      hit      = run && ex_valid && !q_empty && (q_head.pc == ex_pc);
      taken_br = ex_is_branch && ex_taken;
      miss_tgt = run && ex_valid && taken_br &&
                 (!hit || (q_head.target != ex_target));
      miss_dir = hit && !taken_br;
      mispred  = miss_tgt || miss_dir;
      q_pop    = hit;
      q_flush  = mispred;
      q_push   = run && fe_push && !mispred;
      q_wdata  = '{pc: fe_pc, target: fe_target};
      fe_stall = q_full && !q_pop;
   end

   // FSM next state and registered outputs.
   always_comb begin
      state_d            = BRU_RUN;
      redirect_valid_d   = 1'b0;
      redirect_pc_d      = redirect_pc_q;
      btb_write_d        = 1'b0;
      btb_new_pc_d       = btb_new_pc_q;
      btb_data_d         = btb_data_q;
      overflow_d         = overflow_q;
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (run) begin
         if (q_push && q_full && !q_pop) overflow_d = 1'b1;
         if (ex_valid && ex_is_branch && (stat_branches_q != '1))
            stat_branches_d = stat_branches_q + 1'b1;
         if (mispred) begin
            state_d          = BRU_RECOVER;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = miss_tgt ? ex_target : ex_pc + PC_STEP;
            if (stat_mispredicts_q != '1)
               stat_mispredicts_d = stat_mispredicts_q + 1'b1;
         end
         if (miss_tgt) begin
            btb_write_d  = 1'b1;
            btb_new_pc_d = ex_pc;
            btb_data_d   = ex_target;
         end
      end
   end

   // State and output registers; reset overrides everything.
   always_ff @(posedge bru_clk) begin
      if (bru_reset) begin
         state_q            <= BRU_RUN;
         redirect_valid_q   <= 1'b0;
         redirect_pc_q      <= '0;
         btb_write_q        <= 1'b0;
         btb_new_pc_q       <= '0;
         btb_data_q         <= '0;
         overflow_q         <= 1'b0;
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         state_q            <= state_d;
         redirect_valid_q   <= redirect_valid_d;
         redirect_pc_q      <= redirect_pc_d;
         btb_write_q        <= btb_write_d;
         btb_new_pc_q       <= btb_new_pc_d;
         btb_data_q         <= btb_data_d;
         overflow_q         <= overflow_d;
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign btb_write        = btb_write_q;
   assign btb_new_pc       = btb_new_pc_q;
   assign btb_data         = btb_data_q;
   assign overflow         = overflow_q;
   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit.
// Reference model tracks predictions as a plain queue.
module tb_branch_resolve_unit;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic        rv;
      logic [31:0] rpc;
      logic        bw;
      logic [31:0] bnpc;
      logic [31:0] bdata;
      logic        ovf;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        fe_push;
   logic [31:0] fe_pc;
   logic [31:0] fe_target;
   logic        fe_stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_branch;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        btb_write;
   logic [31:0] btb_new_pc;
   logic [31:0] btb_data;
   logic        overflow;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int   checks = 0;
   int   errors = 0;
   exp_t expq[$];
   exp_t m;
   bit   m_rec;
   logic [63:0] mq[$];
   exp_t mon_e;
   exp_t mon_a;

   branch_resolve_unit #(.DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
      .bru_clk          (clk),
      .bru_reset        (rst),
      .fe_push          (fe_push),
      .fe_pc            (fe_pc),
      .fe_target        (fe_target),
      .fe_stall         (fe_stall),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_is_branch     (ex_is_branch),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .btb_write        (btb_write),
      .btb_new_pc       (btb_new_pc),
      .btb_data         (btb_data),
      .overflow         (overflow),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare registered outputs after each edge.
   always @(posedge clk) begin
      #1;
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         mon_a = '{redirect_valid, redirect_pc, btb_write,
                   btb_new_pc, btb_data, overflow,
                   stat_branches, stat_mispredicts};
         checks++;
         if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL outputs t=%0t got rv=%b rpc=%h bw=%b npc=%h dat=%h ovf=%b sb=%0d sm=%0d exp rv=%b rpc=%h bw=%b npc=%h dat=%h ovf=%b sb=%0d sm=%0d",
                     $time, mon_a.rv, mon_a.rpc, mon_a.bw, mon_a.bnpc,
                     mon_a.bdata, mon_a.ovf, mon_a.sb, mon_a.sm,
                     mon_e.rv, mon_e.rpc, mon_e.bw, mon_e.bnpc,
                     mon_e.bdata, mon_e.ovf, mon_e.sb, mon_e.sm);
         end
      end
   end

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Drive one cycle, check fe_stall, advance the model.
   task automatic cycle(input logic r, input logic p,
                        input logic [31:0] fpc, input logic [31:0] ftg,
                        input logic ev, input logic [31:0] epc,
                        input logic br, input logic tk,
                        input logic [31:0] etg);
      bit          hit;
      bit          mis;
      bit          wr;
      bit          stall;
      logic [31:0] cpc;
      @(negedge clk);
      rst = r; fe_push = p; fe_pc = fpc; fe_target = ftg;
      ex_valid = ev; ex_pc = epc; ex_is_branch = br;
      ex_taken = tk; ex_target = etg;
      hit = 0; mis = 0; wr = 0; cpc = '0;
      if (!m_rec && ev && mq.size() > 0)
         hit = (mq[0][63:32] == epc);
      stall = (mq.size() == DEPTH) && !hit;
      #1;
      if (!r) begin
         checks++;
         if (fe_stall !== stall) begin
            errors++;
            $display("FAIL fe_stall t=%0t got %b exp %b",
                     $time, fe_stall, stall);
         end
      end
      m.rv = 0;
      m.bw = 0;
      if (r) begin
         m = '0;
         m_rec = 0;
         mq.delete();
      end else if (m_rec) begin
         m_rec = 0;
      end else begin
         if (ev && br && tk) begin
            mis = !hit || (mq[0][31:0] != etg);
            wr  = mis;
            cpc = etg;
         end else if (hit) begin
            mis = 1;
            cpc = epc + 32'd4;
         end
         if (ev && br) m.sb = sat_inc(m.sb);
         if (mis) begin
            m.sm  = sat_inc(m.sm);
            m.rv  = 1;
            m.rpc = cpc;
            m_rec = 1;
            mq.delete();
            if (wr) begin
               m.bw    = 1;
               m.bnpc  = epc;
               m.bdata = etg;
            end
         end else begin
            if (hit) void'(mq.pop_front());
            if (p) begin
               if (mq.size() < DEPTH) mq.push_back({fpc, ftg});
               else m.ovf = 1;
            end
         end
      end
      expq.push_back(m);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] tg);
      cycle(0, 1, pc, tg, 0, 0, 0, 0, 0);
   endtask

   task automatic ex(input logic [31:0] pc, input logic br,
                     input logic tk, input logic [31:0] tg);
      cycle(0, 0, 0, 0, 1, pc, br, tk, tg);
   endtask

   initial begin
      rst = 1; fe_push = 0; fe_pc = 0; fe_target = 0;
      ex_valid = 0; ex_pc = 0; ex_is_branch = 0;
      ex_taken = 0; ex_target = 0;
      m = '0; m_rec = 0;
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();

      // taken branch with empty queue
      ex(32'h100, 1, 1, 32'h200);
      idle();
      idle();

      // correctly predicted taken branch
      push(32'h100, 32'h200);
      ex(32'h100, 1, 1, 32'h200);
      idle();

      // matched but not taken, then flushed record
      push(32'h100, 32'h200);
      push(32'h180, 32'h300);
      ex(32'h100, 1, 0, 32'h0);
      idle();
      ex(32'h180, 1, 1, 32'h300);
      idle();

      // fill, overflow, push+pop while full, drain
      for (int i = 0; i < DEPTH; i++)
         push(32'h400 + 4 * i, 32'h800 + 4 * i);
      push(32'h4F0, 32'h8F0);
      cycle(0, 1, 32'h4F4, 32'h8F4, 1, 32'h400, 1, 1, 32'h800);
      idle();
      for (int i = 1; i < DEPTH; i++)
         ex(32'h400 + 4 * i, 1, 1, 32'h800 + 4 * i);
      ex(32'h4F4, 1, 1, 32'h8F4);
      idle();

      // pushes during mispredict and RECOVER are dropped
      push(32'h500, 32'h600);
      cycle(0, 1, 32'h510, 32'h610, 1, 32'h500, 1, 1, 32'h700);
      cycle(0, 1, 32'h520, 32'h620, 1, 32'h520, 0, 0, 0);
      ex(32'h510, 0, 0, 0);
      ex(32'h520, 0, 0, 0);
      idle();

      // non-branch alias and PC wrap
      push(32'h600, 32'h640);
      ex(32'h600, 0, 0, 0);
      idle();
      push(32'hFFFF_FFFC, 32'h10);
      ex(32'hFFFF_FFFC, 1, 0, 0);
      idle();

      // saturation, then reset during RECOVER
      @(posedge clk);
      #2;
      force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
      m.sm = 32'hFFFF_FFFF;
      idle();
      release dut.stat_mispredicts_q;
      ex(32'h900, 1, 1, 32'h940);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic        r;
         logic        p;
         logic [31:0] fpc;
         logic [31:0] ftg;
         logic        ev;
         logic [31:0] epc;
         logic        br;
         logic        tk;
         logic [31:0] etg;
         r   = ($urandom % 250) == 0;
         p   = ($urandom % 100) < 55;
         fpc = 32'h1000 + ($urandom % 16) * 4;
         if (($urandom % 40) == 0) fpc = 32'hFFFF_FFFC;
         ftg = 32'h2000 + ($urandom % 4) * 4;
         ev  = ($urandom % 100) < 45;
         br  = ($urandom % 100) < 80;
         tk  = $urandom % 2;
         epc = 32'h1000 + ($urandom % 16) * 4;
         etg = 32'h2000 + ($urandom % 4) * 4;
         if (mq.size() > 0 && ($urandom % 100) < 70) begin
            epc = mq[0][63:32];
            if (($urandom % 3) != 0) etg = mq[0][31:0];
         end
         cycle(r, p, fpc, ftg, ev, epc, br, tk, etg);
      end
      idle();

      @(posedge clk);
      #2;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
